// File: rtl/display_pkg.sv
// Shared constants for the clock display path: segment table, blank
// pattern and value limits. Patterns are stored active-low, {g..a}.
package display_pkg;

  localparam logic [5:0] MAX_MINUTES = 6'd59;
  localparam logic [5:0] MAX_HOURS   = 6'd23;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low patterns for digits 0-9, bit0=a ... bit6=g
  localparam logic [6:0] SEG_DIGITS [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  // Apply output polarity to an active-low pattern
  function automatic logic [6:0] apply_polarity(input logic [6:0] pat_low,
                                                input logic       active_low);
    logic [6:0] result;
    if (active_low) begin
      result = pat_low;
    end else begin
      result = ~pat_low;
    end
    return result;
  endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational digit-to-segment lookup with a blank override.
module seg_decoder
  import display_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] pattern
);

  logic [6:0] pattern_low_s;

  // Select the active-low pattern; non-decimal codes fall back to blank
  always_comb begin
    pattern_low_s = SEG_BLANK;
    if (blank) begin
      pattern_low_s = SEG_BLANK;
    end else if (digit <= 4'd9) begin
      pattern_low_s = SEG_DIGITS[digit];
    end else begin
      pattern_low_s = SEG_BLANK;
    end
  end

  assign pattern = apply_polarity(pattern_low_s, SEG_ACTIVE_LOW);

endmodule

// File: rtl/display_driver.sv
// One seven-segment digit of a clock display: 12/24-hour conversion,
// decimal digit selection, blanking and a registered segment output.
module display_driver
  import display_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] number,
  input  logic       tens,
  input  logic       hoursPlace,
  input  logic       set24hours,
  output logic [6:0] seg
);

  localparam logic [6:0] BLANK_OUT = SEG_ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK;

  logic [5:0] value_s;
  logic [5:0] digit_full_s;
  logic       out_of_range_s;
  logic       suppress_s;
  logic       blank_s;
  logic [6:0] seg_d;
  logic [6:0] seg_q;

  // Map the input to the value shown and pick its tens or units digit
  always_comb begin
    value_s = number;
    if (hoursPlace && !set24hours) begin
      if (number == 6'd0) begin
        value_s = 6'd12;
      end else if (number > 6'd12) begin
        value_s = number - 6'd12;
      end else begin
        value_s = number;
      end
    end else begin
      value_s = number;
    end

    digit_full_s = 6'd0;
    if (tens) begin
      digit_full_s = value_s / 6'd10;
    end else begin
      digit_full_s = value_s % 6'd10;
    end
  end

  // Decide blanking: range check on the raw input, and leading-zero
  // suppression only for the 12-hour hours tens digit
  always_comb begin
    out_of_range_s = 1'b0;
    if (hoursPlace) begin
      out_of_range_s = (number > MAX_HOURS);
    end else begin
      out_of_range_s = (number > MAX_MINUTES);
    end
    suppress_s = hoursPlace && !set24hours && tens && (digit_full_s == 6'd0);
    blank_s    = out_of_range_s || suppress_s || (digit_full_s > 6'd9);
  end

  seg_decoder #(
    .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
  ) u_seg_decoder (
    .digit  (digit_full_s[3:0]),
    .blank  (blank_s),
    .pattern(seg_d)
  );

  // Output register; reset blanks the display ahead of any input
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q <= BLANK_OUT;
    end else begin
      seg_q <= seg_d;
    end
  end

  assign seg = seg_q;

endmodule

// File: tb/tb_display_driver.sv
// Self-checking bench for display_driver (both segment polarities).
module tb_display_driver;

  logic       clk;
  logic       reset;
  logic [5:0] number;
  logic       tens;
  logic       hoursPlace;
  logic       set24hours;
  logic [6:0] seg_lo;
  logic [6:0] seg_hi;

  int checks;
  int errors;

  display_driver #(.SEG_ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .reset(reset), .number(number), .tens(tens),
    .hoursPlace(hoursPlace), .set24hours(set24hours), .seg(seg_lo)
  );

  display_driver #(.SEG_ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .reset(reset), .number(number), .tens(tens),
    .hoursPlace(hoursPlace), .set24hours(set24hours), .seg(seg_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the displayed pattern from the rules, active-low
  function automatic logic [6:0] model(input int n, input bit t, input bit h, input bit m24);
    logic [6:0] tbl [10];
    int v;
    int d;
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    if (h && n > 23) return 7'h7F;
    if (!h && n > 59) return 7'h7F;
    v = n;
    if (h && !m24) begin
      if (n == 0) v = 12;
      else if (n > 12) v = n - 12;
    end
    d = t ? v / 10 : v % 10;
    if (h && !m24 && t && d == 0) return 7'h7F;
    return tbl[d];
  endfunction

  // Apply inputs at a falling edge, let one rising edge pass, return at next falling edge
  task automatic step(input int n, input bit t, input bit h, input bit m24);
    number     = 6'(n);
    tens       = t;
    hoursPlace = h;
    set24hours = m24;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(8, 1'b0, 1'b0, 1'b0);   // an "8" would light everything; reset must win
    checks++;
    if (seg_lo !== 7'h7F) begin
      errors++; $display("FAIL reset_blank: got %h expected %h", seg_lo, 7'h7F);
    end
    checks++;
    if (seg_hi !== 7'h00) begin
      errors++; $display("FAIL reset_blank_hi: got %h expected %h", seg_hi, 7'h00);
    end
    reset = 1'b0;
  endtask

  task automatic test_minutes();
    step(37, 1'b0, 1'b0, 1'b0);
    checks++;
    if (seg_lo !== 7'h78) begin
      errors++; $display("FAIL min37_units: got %h expected %h", seg_lo, 7'h78);
    end
    step(37, 1'b1, 1'b0, 1'b0);
    checks++;
    if (seg_lo !== 7'h30) begin
      errors++; $display("FAIL min37_tens: got %h expected %h", seg_lo, 7'h30);
    end
    step(5, 1'b1, 1'b0, 1'b1);
    checks++;
    if (seg_lo !== 7'h40) begin
      errors++; $display("FAIL min05_tens_zero: got %h expected %h", seg_lo, 7'h40);
    end
  endtask

  task automatic test_12h();
    step(13, 1'b0, 1'b1, 1'b0);
    checks++;
    if (seg_lo !== 7'h79) begin
      errors++; $display("FAIL h13_units: got %h expected %h", seg_lo, 7'h79);
    end
    step(13, 1'b1, 1'b1, 1'b0);
    checks++;
    if (seg_lo !== 7'h7F) begin
      errors++; $display("FAIL h13_tens_blank: got %h expected %h", seg_lo, 7'h7F);
    end
    step(0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (seg_lo !== 7'h24) begin
      errors++; $display("FAIL h00_units_12h: got %h expected %h", seg_lo, 7'h24);
    end
    step(0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (seg_lo !== 7'h79) begin
      errors++; $display("FAIL h00_tens_12h: got %h expected %h", seg_lo, 7'h79);
    end
    step(12, 1'b1, 1'b1, 1'b0);
    checks++;
    if (seg_lo !== 7'h79) begin
      errors++; $display("FAIL h12_tens_12h: got %h expected %h", seg_lo, 7'h79);
    end
  endtask

  task automatic test_24h();
    step(0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (seg_lo !== 7'h40) begin
      errors++; $display("FAIL h00_tens_24h: got %h expected %h", seg_lo, 7'h40);
    end
    step(23, 1'b0, 1'b1, 1'b1);
    checks++;
    if (seg_lo !== 7'h30) begin
      errors++; $display("FAIL h23_units_24h: got %h expected %h", seg_lo, 7'h30);
    end
    step(23, 1'b1, 1'b1, 1'b1);
    checks++;
    if (seg_lo !== 7'h24) begin
      errors++; $display("FAIL h23_tens_24h: got %h expected %h", seg_lo, 7'h24);
    end
  endtask

  task automatic test_out_of_range();
    step(60, 1'b0, 1'b0, 1'b1);
    checks++;
    if (seg_lo !== 7'h7F) begin
      errors++; $display("FAIL min60_blank: got %h expected %h", seg_lo, 7'h7F);
    end
    step(24, 1'b0, 1'b1, 1'b1);
    checks++;
    if (seg_lo !== 7'h7F) begin
      errors++; $display("FAIL h24_blank: got %h expected %h", seg_lo, 7'h7F);
    end
    step(59, 1'b1, 1'b0, 1'b0);
    checks++;
    if (seg_lo !== 7'h12) begin
      errors++; $display("FAIL min59_tens: got %h expected %h", seg_lo, 7'h12);
    end
  endtask

  task automatic test_midstream_reset();
    step(48, 1'b0, 1'b0, 1'b0);
    checks++;
    if (seg_lo !== 7'h00) begin
      errors++; $display("FAIL pre_reset_8: got %h expected %h", seg_lo, 7'h00);
    end
    reset = 1'b1;
    step(48, 1'b0, 1'b0, 1'b0);
    checks++;
    if (seg_lo !== 7'h7F) begin
      errors++; $display("FAIL midstream_reset: got %h expected %h", seg_lo, 7'h7F);
    end
    reset = 1'b0;
    step(48, 1'b0, 1'b0, 1'b0);
    checks++;
    if (seg_lo !== 7'h00) begin
      errors++; $display("FAIL post_reset_8: got %h expected %h", seg_lo, 7'h00);
    end
  endtask

  // Inputs change every cycle; each falling edge checks the previous cycle's inputs
  task automatic test_back_to_back_sweep();
    logic [6:0] exp_prev;
    bit have_prev;
    have_prev = 1'b0;
    exp_prev  = 7'h7F;
    for (int mode = 0; mode < 4; mode++) begin
      for (int n = 0; n < 60; n++) begin
        for (int t = 0; t < 2; t++) begin
          if (have_prev) begin
            checks++;
            if (seg_lo !== exp_prev || seg_hi !== ~exp_prev) begin
              errors++;
              $display("FAIL sweep: got lo=%h hi=%h expected lo=%h hi=%h", seg_lo, seg_hi, exp_prev, ~exp_prev);
            end
          end
          number     = 6'(n);
          tens       = t[0];
          hoursPlace = mode[1];
          set24hours = mode[0];
          exp_prev   = model(n, t[0], mode[1], mode[0]);
          have_prev  = 1'b1;
          @(negedge clk);
        end
      end
    end
    checks++;
    if (seg_lo !== exp_prev) begin
      errors++; $display("FAIL sweep_last: got %h expected %h", seg_lo, exp_prev);
    end
  endtask

  // Random inputs including out-of-range values and occasional reset
  task automatic test_random();
    logic [6:0] exp_prev;
    int n;
    bit t, h, m, r;
    reset = 1'b0;
    step(1, 1'b0, 1'b0, 1'b0);
    exp_prev = 7'h79;
    for (int i = 0; i < 400; i++) begin
      checks++;
      if (seg_lo !== exp_prev || seg_hi !== ~exp_prev) begin
        errors++;
        $display("FAIL random: got lo=%h hi=%h expected lo=%h", seg_lo, seg_hi, exp_prev);
      end
      n = $urandom_range(0, 63);
      t = 1'($urandom_range(0, 1));
      h = 1'($urandom_range(0, 1));
      m = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 15) == 0);
      number = 6'(n); tens = t; hoursPlace = h; set24hours = m; reset = r;
      exp_prev = r ? 7'h7F : model(n, t, h, m);
      @(negedge clk);
    end
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1; number = 6'd0; tens = 1'b0; hoursPlace = 1'b0; set24hours = 1'b0;
    @(negedge clk);
    test_reset();
    test_minutes();
    test_12h();
    test_24h();
    test_out_of_range();
    test_midstream_reset();
    test_back_to_back_sweep();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
